// File: rtl/mux_arbiter_2.sv
// Two-client round-robin arbiter that owns the select of a 2:1 bit mux and registers the mux output.
// Define MUX_ARB_TIMEOUT_EN to preempt a holder after MAX_HOLD consecutive grant cycles.
module mux_arbiter_2 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] i,
  output logic [1:0] gnt,
  output logic       s,
  output logic       o,
  output logic       busy
);

  localparam bit CFG_OK = (MAX_HOLD >= 1) && (MAX_HOLD <= 255) && (MAX_HOLD < (1 << CNT_W));

  if (!CFG_OK) begin : g_bad_cfg
    $error("mux_arbiter_2: MAX_HOLD must be 1..255 and below 2**CNT_W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t     state_r;
  state_t     next_state_s;
  logic       last_r;
  logic       timeout_s;
  logic [1:0] gnt_r;
  logic       s_r;
  logic       o_r;
  logic       busy_r;
  logic [1:0] gnt_nx_s;
  logic       s_nx_s;
  logic       o_nx_s;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] hcnt_r;

  assign timeout_s = (hcnt_r == HOLD_LAST);

  // Hold counter: restarts on every state entry, saturates at the last allowed cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_r <= '0;
    end else if (next_state_s != state_r) begin
      hcnt_r <= '0;
    end else if ((state_r != IDLE) && !timeout_s) begin
      hcnt_r <= hcnt_r + CNT_W'(1);
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state selection: round-robin in IDLE, direct handover between grants.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        case (req)
          2'b01:   next_state_s = GNT0;
          2'b10:   next_state_s = GNT1;
          2'b11:   next_state_s = last_r ? GNT0 : GNT1;
          default: next_state_s = IDLE;
        endcase
      end
      GNT0: begin
        if (!req[0]) begin
          next_state_s = req[1] ? GNT1 : IDLE;
        end else if (timeout_s && req[1]) begin
          next_state_s = GNT1;
        end else begin
          next_state_s = GNT0;
        end
      end
      GNT1: begin
        if (!req[1]) begin
          next_state_s = req[0] ? GNT0 : IDLE;
        end else if (timeout_s && req[0]) begin
          next_state_s = GNT0;
        end else begin
          next_state_s = GNT1;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output values for the coming cycle; select and data hold their last value in IDLE.
  always_comb begin
    gnt_nx_s = 2'b00;
    s_nx_s   = s_r;
    o_nx_s   = o_r;
    case (next_state_s)
      GNT0: begin
        gnt_nx_s = 2'b01;
        s_nx_s   = 1'b0;
        o_nx_s   = i[0];
      end
      GNT1: begin
        gnt_nx_s = 2'b10;
        s_nx_s   = 1'b1;
        o_nx_s   = i[1];
      end
      default: begin
        gnt_nx_s = 2'b00;
      end
    endcase
  end

  // State, round-robin pointer and registered outputs; last=1 lets client 0 win first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      gnt_r   <= 2'b00;
      s_r     <= 1'b0;
      o_r     <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      gnt_r   <= gnt_nx_s;
      s_r     <= s_nx_s;
      o_r     <= o_nx_s;
      busy_r  <= |gnt_nx_s;
      if (next_state_s == GNT0) begin
        last_r <= 1'b0;
      end else if (next_state_s == GNT1) begin
        last_r <= 1'b1;
      end
    end
  end

  assign gnt  = gnt_r;
  assign s    = s_r;
  assign o    = o_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_mux_arbiter_2.sv
// Self-checking bench for mux_arbiter_2: directed vector table, corner-case sequences, random run.
module tb_mux_arbiter_2;
  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] i = 2'b00;
  logic [1:0] gnt;
  logic       s;
  logic       o;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state: owner -1 = idle
  int         own_m;
  int         last_m;
  int         hold_m;
  logic       s_m;
  logic       o_m;
  logic [1:0] prev_i;

  typedef struct packed {
    logic [1:0] req;
    logic [1:0] d;
    logic [1:0] gnt;
    logic       s;
    logic       o;
  } vec_t;

  vec_t tbl[14];

  mux_arbiter_2 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .i    (i),
    .gnt  (gnt),
    .s    (s),
    .o    (o),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    own_m  = -1;
    last_m = 1;
    hold_m = 0;
    s_m    = 1'b0;
    o_m    = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] r, input logic [1:0] d);
    int nxt;
    int oth;
    if (own_m < 0) begin
      if (r == 2'b00)      nxt = -1;
      else if (r == 2'b11) nxt = 1 - last_m;
      else                 nxt = r[1] ? 1 : 0;
    end else begin
      oth = 1 - own_m;
      if (!r[own_m]) nxt = r[oth] ? oth : -1;
      else           nxt = own_m;
`ifdef MUX_ARB_TIMEOUT_EN
      if (r[own_m] && r[oth] && hold_m == MAX_HOLD - 1) nxt = oth;
`endif
    end
    if (nxt != own_m)                        hold_m = 0;
    else if (own_m >= 0 && hold_m < MAX_HOLD - 1) hold_m++;
    if (nxt >= 0) begin
      last_m = nxt;
      s_m    = nxt[0];
      o_m    = d[nxt];
    end
    own_m = nxt;
  endtask

  task automatic step(input logic [1:0] r, input logic [1:0] d);
    req = r;
    i   = d;
    @(posedge clk);
    model_edge(r, d);
    prev_i = d;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    i     = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic int gnt_of(input int own);
    return (own < 0) ? 0 : ((own == 0) ? 1 : 2);
  endfunction

  initial begin
    int wait0;
    int wait1;
    int max_wait;
    logic [1:0] r;

    //              req    i      gnt    s     o
    tbl[0]  = '{2'b01, 2'b01, 2'b01, 1'b0, 1'b1};
    tbl[1]  = '{2'b01, 2'b00, 2'b01, 1'b0, 1'b0};
    tbl[2]  = '{2'b00, 2'b11, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{2'b11, 2'b10, 2'b10, 1'b1, 1'b1};
    tbl[4]  = '{2'b11, 2'b00, 2'b10, 1'b1, 1'b0};
    tbl[5]  = '{2'b01, 2'b11, 2'b01, 1'b0, 1'b1};
    tbl[6]  = '{2'b10, 2'b10, 2'b10, 1'b1, 1'b1};
    tbl[7]  = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b1};
    tbl[8]  = '{2'b11, 2'b01, 2'b01, 1'b0, 1'b1};
    tbl[9]  = '{2'b10, 2'b01, 2'b10, 1'b1, 1'b0};
    tbl[10] = '{2'b00, 2'b11, 2'b00, 1'b1, 1'b0};
    tbl[11] = '{2'b10, 2'b11, 2'b10, 1'b1, 1'b1};
    tbl[12] = '{2'b10, 2'b01, 2'b10, 1'b1, 1'b0};
    tbl[13] = '{2'b00, 2'b10, 2'b00, 1'b1, 1'b0};

    // reset and idle
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(2'b00, 2'b11);
      chk("idle_gnt", int'(gnt), 0);
      chk("idle_s", int'(s), 0);
      chk("idle_o", int'(o), 0);
      chk("idle_busy", int'(busy), 0);
    end

    // directed table
    for (int k = 0; k < 14; k++) begin
      step(tbl[k].req, tbl[k].d);
      chk($sformatf("tbl%0d_gnt", k), int'(gnt), int'(tbl[k].gnt));
      chk($sformatf("tbl%0d_s", k), int'(s), int'(tbl[k].s));
      chk($sformatf("tbl%0d_o", k), int'(o), int'(tbl[k].o));
      chk($sformatf("tbl%0d_busy", k), int'(busy), int'(tbl[k].gnt != 2'b00));
    end

    // fairness after reset, gapless handover, round-robin from idle
    do_reset();
    step(2'b11, 2'b00);
    chk("fair_first", int'(gnt), 1);
    step(2'b10, 2'b00);
    chk("fair_handover", int'(gnt), 2);
    step(2'b00, 2'b00);
    chk("fair_idle", int'(gnt), 0);
    step(2'b11, 2'b00);
    chk("fair_rr", int'(gnt), 1);

    // long contention: preemption only in the timeout build
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(2'b11, k[1:0]);
`ifdef MUX_ARB_TIMEOUT_EN
      chk($sformatf("hold%0d", k), int'(gnt), (((k / MAX_HOLD) % 2) == 0) ? 1 : 2);
`else
      chk($sformatf("hold%0d", k), int'(gnt), 1);
`endif
    end

    // asynchronous reset in the middle of a grant
    do_reset();
    step(2'b10, 2'b10);
    chk("mid_gnt", int'(gnt), 2);
    chk("mid_o", int'(o), 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_gnt", int'(gnt), 0);
    chk("arst_s", int'(s), 0);
    chk("arst_o", int'(o), 0);
    chk("arst_busy", int'(busy), 0);
    #2 rst_n = 1'b1;
    step(2'b11, 2'b01);
    chk("post_rst_gnt", int'(gnt), 1);
    chk("post_rst_o", int'(o), 1);

    // random run against the reference model and invariants
    do_reset();
    wait0 = 0;
    wait1 = 0;
    max_wait = 0;
    for (int k = 0; k < 10000; k++) begin
      r = 2'($urandom_range(0, 3));
      step(r, 2'($urandom_range(0, 3)));
      if (gnt == 2'b11) chk("rnd_never11", int'(gnt), 0);
      if (gnt != 2'(gnt_of(own_m))) chk("rnd_gnt", int'(gnt), gnt_of(own_m));
      if (busy != (gnt != 2'b00)) chk("rnd_busy", int'(busy), int'(gnt != 2'b00));
      if (s != s_m) chk("rnd_s", int'(s), int'(s_m));
      if (o != o_m) chk("rnd_o", int'(o), int'(o_m));
      if (busy && (s != gnt[1])) chk("rnd_s_vs_gnt", int'(s), int'(gnt[1]));
      if (busy && (o != prev_i[s])) chk("rnd_o_vs_i", int'(o), int'(prev_i[s]));
      wait0 = (r[0] && !gnt[0]) ? wait0 + 1 : 0;
      wait1 = (r[1] && !gnt[1]) ? wait1 + 1 : 0;
      if (wait0 > max_wait) max_wait = wait0;
      if (wait1 > max_wait) max_wait = wait1;
    end
    n_tests++;
`ifdef MUX_ARB_TIMEOUT_EN
    chk("rnd_max_wait", (max_wait <= MAX_HOLD + 1) ? 1 : 0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
